spectrum_peak_hold: RTL

SPECTRUM_PEAK_HOLD -- requirements
Module: spectrum_peak_hold

---
 rtl/spectrum_peak_hold.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spectrum_peak_hold.sv
// ============================================================================
//  Module      : spectrum_peak_hold
//  Description : Per-bin spectrum peak-hold with linear decay. It keeps one
//                held value per bin in a read-modify-write memory and has an
//                independent registered read port for the display.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_peak_hold #(
    parameter int NBINS = 256,
    parameter int AW    = 8,
    parameter int DECAY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          peak_mode,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_done,
    output logic          frame_err,
    output logic [AW-1:0] bin_idx
);

    localparam logic [AW-1:0] c_LAST_BIN = AW'(NBINS - 1);
    localparam logic [7:0]    c_DECAY    = 8'(DECAY);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_addr;
    logic [7:0]    r_mem [NBINS];

    // Pipeline stage between the memory read and the write-back
    logic          r_s1_valid;
    logic          r_s1_mode;
    logic          r_s1_end;
    logic [AW-1:0] r_s1_addr;
    logic [7:0]    r_s1_data;
    logic [7:0]    r_s1_old;

    logic          w_accept;
    logic          w_at_last_bin;
    logic          w_frame_end;
    logic          w_len_err;
    logic          w_wr_en;
    logic          w_fwd;
    logic [7:0]    w_decayed;
    logic [7:0]    w_result;

    assign w_accept      = in_valid && in_ready;
    assign w_at_last_bin = (bin_idx == c_LAST_BIN);
    assign w_frame_end   = in_last || w_at_last_bin;
    assign w_len_err     = in_last != w_at_last_bin;
    // A write still pending when reset arrives is discarded
    assign w_wr_en       = r_s1_valid && !reset;
    // A one-bin frame makes consecutive samples hit the same bin; forward the
    // result that is being written so the read sees the updated value
    assign w_fwd         = w_wr_en && (r_s1_addr == bin_idx);

    assign w_decayed = (r_s1_old > c_DECAY) ? (r_s1_old - c_DECAY) : 8'd0;
    assign w_result  = !r_s1_mode ? r_s1_data :
                       ((r_s1_data > w_decayed) ? r_s1_data : w_decayed);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_CLEAR;
        else       r_state <= w_state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == c_LAST_BIN) w_state_next = ST_RUN;
            ST_RUN:   in_ready = 1'b1;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    // Clear-sweep address
    always_ff @(posedge clk) begin
        if (reset)                   r_clr_addr <= '0;
        else if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + AW'(1);
    end

    // Bin index advances per accepted sample and wraps at every frame end
    always_ff @(posedge clk) begin
        if (reset)         bin_idx <= '0;
        else if (w_accept) bin_idx <= w_frame_end ? '0 : bin_idx + AW'(1);
    end

    // Sticky frame-length error
    always_ff @(posedge clk) begin
        if (reset)                       frame_err <= 1'b0;
        else if (w_accept && w_len_err)  frame_err <= 1'b1;
    end

    // Capture the accepted sample together with the old held value
    always_ff @(posedge clk) begin
        if (reset) r_s1_valid <= 1'b0;
        else       r_s1_valid <= w_accept;
        if (w_accept) begin
            r_s1_mode <= peak_mode;
            r_s1_end  <= w_frame_end;
            r_s1_addr <= bin_idx;
            r_s1_data <= in_data;
            r_s1_old  <= w_fwd ? w_result : r_mem[bin_idx];
        end
    end

    // Memory write port: zero sweep during CLEAR, write-back during RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) r_mem[r_clr_addr] <= 8'd0;
            else if (w_wr_en)        r_mem[r_s1_addr]  <= w_result;
        end
    end

    // Display read port; same-cycle write to the address returns the old value
    always_ff @(posedge clk) begin
        if (reset) rd_data <= 8'd0;
        else       rd_data <= r_mem[rd_addr];
    end

    // Frame-done pulse once the frame-ending write has landed
    always_ff @(posedge clk) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= w_wr_en && r_s1_end;
    end

endmodule

`default_nettype wire
